my_fifo_4: RTL and testbench

- 4-entry, WIDTH-bit synchronous FIFO.
- Sits directly downstream of the 4-way write-strobe demultiplexer.
- A single push strobe is steered by the 2-bit write pointer through my_dmux_4_way into exactly one of four enable registers.
- Read side is show-ahead: the head word is always visible at out_data.
- Used as the buffering stage between word producers and consumers in the Hack-style datapath.

---
 rtl/my_fifo_pkg.sv | 10 +
 rtl/my_fifo_4_if.sv | 26 ++
 rtl/my_dmux_4_way.sv | 14 +
 rtl/my_register.sv | 18 +
 rtl/my_fifo_4.sv | 96 +++++++++
 tb/tb_my_fifo_4.sv | 150 +++++++++++++++
 6 files changed

// File: rtl/my_fifo_pkg.sv
// rtl/my_fifo_pkg.sv - shared sizes and types for the 4-entry FIFO
package my_fifo_pkg;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;
  localparam int WORD_W     = 16;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/my_fifo_4_if.sv
// rtl/my_fifo_4_if.sv - push/pop/data bundle between a FIFO and its user
interface my_fifo_4_if
  import my_fifo_pkg::*;
#(
  parameter int WIDTH = WORD_W
);
  logic [WIDTH-1:0] in_data;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] out_data;
  logic             empty;
  logic             full;
  cnt_t             count;
  logic             overflow;
  logic             underflow;

  modport master (
    output in_data, push, pop,
    input  out_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  in_data, push, pop,
    output out_data, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/my_dmux_4_way.sv
// rtl/my_dmux_4_way.sv - steers one input bit to one of four outputs by sel
module my_dmux_4_way (
  input  logic       in,
  input  logic [1:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d
);
  assign a = in & (sel == 2'd0);
  assign b = in & (sel == 2'd1);
  assign c = in & (sel == 2'd2);
  assign d = in & (sel == 2'd3);
endmodule

// File: rtl/my_register.sv
// rtl/my_register.sv - WIDTH-bit load-enable register, async active-high clear
module my_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end
endmodule

// File: rtl/my_fifo_4.sv
// rtl/my_fifo_4.sv - 4-entry show-ahead FIFO with registered overflow/underflow pulses
module my_fifo_4
  import my_fifo_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input logic         clk,
  input logic         reset,
  my_fifo_4_if.slave  f
);
  logic             push_ok;
  logic             pop_ok;
  logic             empty_w;
  logic             full_w;
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  cnt_t             count_q;
  cnt_t             count_nx;
  logic [3:0]       wr_en;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             ov_q;
  logic             un_q;

  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == cnt_t'(FIFO_DEPTH));
  assign push_ok  = f.push & ~full_w;
  assign pop_ok   = f.pop & ~empty_w;
  assign count_nx = count_q + cnt_t'(push_ok) - cnt_t'(pop_ok);

  my_dmux_4_way u_wr_dmux (
    .in  (push_ok),
    .sel (wr_ptr),
    .a   (wr_en[0]),
    .b   (wr_en[1]),
    .c   (wr_en[2]),
    .d   (wr_en[3])
  );

  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_mem
    my_register #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .reset (reset),
      .load  (wr_en[i]),
      .d     (f.in_data),
      .q     (mem[i])
    );
  end

  my_register #(.WIDTH(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .load  (push_ok),
    .d     (wr_ptr + ptr_t'(1)),
    .q     (wr_ptr)
  );

  my_register #(.WIDTH(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .load  (pop_ok),
    .d     (rd_ptr + ptr_t'(1)),
    .q     (rd_ptr)
  );

  my_register #(.WIDTH(CNT_W)) u_count (
    .clk   (clk),
    .reset (reset),
    .load  (push_ok | pop_ok),
    .d     (count_nx),
    .q     (count_q)
  );

  // Error flags reload every edge so each rejection shows for exactly one cycle.
  my_register #(.WIDTH(1)) u_overflow (
    .clk   (clk),
    .reset (reset),
    .load  (1'b1),
    .d     (f.push & full_w),
    .q     (ov_q)
  );

  my_register #(.WIDTH(1)) u_underflow (
    .clk   (clk),
    .reset (reset),
    .load  (1'b1),
    .d     (f.pop & empty_w),
    .q     (un_q)
  );

  assign f.out_data  = mem[rd_ptr];
  assign f.empty     = empty_w;
  assign f.full      = full_w;
  assign f.count     = count_q;
  assign f.overflow  = ov_q;
  assign f.underflow = un_q;
endmodule

// File: tb/tb_my_fifo_4.sv
// tb/tb_my_fifo_4.sv - randomized and directed bench for my_fifo_4 against a queue model
module tb_my_fifo_4;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  my_fifo_4_if #(.WIDTH(16)) bus ();

  my_fifo_4 #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .f     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] model_q [$];
  bit          exp_ov;
  bit          exp_un;
  int          m_n;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
      exp_ov = 1'b0;
      exp_un = 1'b0;
    end else begin
      m_n    = model_q.size();
      exp_ov = bus.push && (m_n == 4);
      exp_un = bus.pop && (m_n == 0);
      if (bus.pop && m_n > 0) void'(model_q.pop_front());
      if (bus.push && m_n < 4) model_q.push_back(bus.in_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_count", 32'(bus.count), 32'(model_q.size()));
      chk("model_empty", 32'(bus.empty), 32'(model_q.size() == 0));
      chk("model_full", 32'(bus.full), 32'(model_q.size() == 4));
      chk("model_overflow", 32'(bus.overflow), 32'(exp_ov));
      chk("model_underflow", 32'(bus.underflow), 32'(exp_un));
      if (model_q.size() > 0) chk("model_out_data", 32'(bus.out_data), 32'(model_q[0]));
    end
  end

  task automatic cyc(input bit p, input bit o, input logic [15:0] d);
    bus.push    = p;
    bus.pop     = o;
    bus.in_data = d;
    @(posedge clk);
    #3;
  endtask

  logic [15:0] fill_words [4];

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.in_data = '0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    repeat (3) cyc(0, 0, 16'h0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_underflow", 32'(bus.underflow), 32'd0);

    fill_words[0] = 16'h1111;
    fill_words[1] = 16'h2222;
    fill_words[2] = 16'h3333;
    fill_words[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, fill_words[i]);
      chk("fill_count", 32'(bus.count), 32'(i + 1));
      chk("fill_head", 32'(bus.out_data), 32'h1111);
    end
    chk("fill_full", 32'(bus.full), 32'd1);

    cyc(1, 0, 16'h5555);
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd4);
    cyc(0, 0, 16'h0);
    chk("ovf_clear", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", 32'(bus.out_data), 32'(fill_words[i]));
      cyc(0, 1, 16'h0);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);

    cyc(1, 1, 16'hAAAA);
    chk("unf_count", 32'(bus.count), 32'd1);
    chk("unf_head", 32'(bus.out_data), 32'hAAAA);
    chk("unf_pulse", 32'(bus.underflow), 32'd1);
    cyc(0, 1, 16'h0);
    chk("unf_clear", 32'(bus.underflow), 32'd0);
    chk("unf_empty", 32'(bus.empty), 32'd1);

    for (int i = 1; i <= 3; i++) cyc(1, 0, 16'(16'hF000 + i));
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 1, 16'(16'h0101 * k));
      chk("wrap_count", 32'(bus.count), 32'd3);
    end
    chk("wrap_head0", 32'(bus.out_data), 32'h0404);
    cyc(0, 1, 16'h0);
    chk("wrap_head1", 32'(bus.out_data), 32'h0505);
    cyc(0, 1, 16'h0);
    chk("wrap_head2", 32'(bus.out_data), 32'h0606);
    cyc(0, 1, 16'h0);
    chk("wrap_empty", 32'(bus.empty), 32'd1);

    cyc(1, 0, 16'h1234);
    cyc(1, 0, 16'h5678);
    bus.push = 1'b0;
    reset    = 1'b1;
    #1;
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    cyc(1, 0, 16'hBEEF);
    chk("post_rst_head", 32'(bus.out_data), 32'hBEEF);
    chk("post_rst_count", 32'(bus.count), 32'd1);

    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45), 16'($urandom));
    end
    cyc(0, 0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
